fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage with a variable-latency instruction-memory handshake.
//  Owns the PC, issues one memory request at a time, and buffers {pc,instr} pairs in a small
//  FIFO for the decode stage. Supports absolute and PC-relative redirects (branch/jump) with flush.
//  Sits between the external instruction memory and the ID stage.
// PARAMETERS
//  ADDR_W      32  PC / memory address width
//  INSTR_W     32  instruction width
//  RESET_PC    0   PC loaded on reset
//  PC_STEP     4   sequential PC increment, in bytes
//  FIFO_DEPTH  2   fetch buffer entries (>=1)
// PORTS
//  clk              in   1        clock, rising edge
//  reset            in   1        synchronous, active-high
//  redirect_valid   in   1        branch taken: redirect fetch this cycle
//  redirect_rel     in   1        1 = target is redirect_base + redirect_target; 0 = absolute
//  redirect_base    in   ADDR_W   base PC for relative redirects (PC of the branch)
//  redirect_target  in   ADDR_W   absolute target, or two's-complement byte offset
//  imem_req         out  1        request valid
//  imem_addr        out  ADDR_W   request address (= fetch PC)
//  imem_gnt         in   1        memory accepts request this cycle
//  imem_rvalid      in   1        read data valid (>=1 cycle after gnt)
//  imem_rdata       in   INSTR_W  instruction data
//  id_valid         out  1        FIFO head valid
//  id_pc            out  ADDR_W   PC of head instruction
//  id_instr         out  INSTR_W  head instruction
//  id_ready         in   1        ID consumes head when id_valid & id_ready
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, state=REQ, FIFO empty; id_valid=0, imem_req=0 during reset.
//  FSM (registered state; imem_req is a function of state and FIFO space):
//   REQ : imem_req=1 if (FIFO entries + 0 outstanding) < FIFO_DEPTH, otherwise 0.
//         On req&gnt, capture req_pc=fetch_pc; fetch_pc += PC_STEP; -> WAIT.
//   WAIT: await imem_rvalid; write {req_pc,imem_rdata} to FIFO; -> REQ.
//   DROP: outstanding response is stale; discard it on imem_rvalid; -> REQ.
//  A slot is reserved at grant, so the FIFO can never overflow on rvalid.
//  Memory samples imem_addr only on gnt; the address may change while req=1 and gnt=0.
//  Redirect (highest priority, effective same cycle):
//   - new_pc = redirect_rel ? redirect_base + redirect_target : redirect_target (mod 2^ADDR_W).
//   - FIFO flushed next cycle; an id handshake in the same cycle is void.
//   - REQ without gnt: fetch_pc=new_pc; imem_addr shows new_pc from the next cycle.
//   - REQ with gnt in the same cycle: old request is issued; -> DROP; fetch_pc=new_pc.
//   - WAIT: -> DROP, or -> REQ if imem_rvalid in the same cycle (data discarded).
//   - DROP: stay in DROP; update fetch_pc.
//  Latency: gnt in cycle N, rvalid in cycle N+k -> id_valid=1 in cycle N+k+1.
//   Best sustained rate: 1 instr / 2 cycles with single-cycle memory.
//  FIFO: simultaneous write and read when full is legal (slot reserved); empty -> id_valid=0.
//  id outputs are held stable while id_valid & !id_ready.
//  Target alignment is the branch unit's responsibility; no checking here.
//  PC wraps modulo 2^ADDR_W with no flag.
//  Reset mid-transaction: state->REQ and FIFO cleared. Memory must also be reset,
//   because a late rvalid is not tracked.
// STRUCTURE
//  fetch_pkg: state enum {REQ,WAIT,DROP}; FIFO pointer-width function ($clog2(FIFO_DEPTH)+1).
//  Sub-module fetch_fifo: sync FIFO with flush, width ADDR_W+INSTR_W, depth FIFO_DEPTH, count out.
//  Top: FSM, PC register, redirect adder, slot-reservation logic.
// TESTING
//  1 Release reset, gnt=1, rvalid 1 cycle later, id_ready=1 -> id_pc 0,4,8,... with instrs in order.
//  2 id_ready=0 with FIFO_DEPTH=2 -> exactly 2 entries buffered, imem_req=0, outputs stable;
//    release id_ready -> fetch resumes at PC 8.
//  3 Absolute redirect to 0x100 while in WAIT -> late response dropped, next id_pc=0x100,
//    no stale id_valid.
//  4 Relative redirect, base=0x20, target=0xFFFFFFF0 -> next fetch at 0x10; with FIFO full,
//    FIFO flushed on the next cycle.
//  5 redirect coincident with gnt, and separately coincident with rvalid -> DROP/REQ paths
//    taken, and stale instr never reaches ID.
//  6 Variable latency 1..5 plus random gnt stalls vs. reference model; PC wrap from 0xFFFFFFFC
//    to 0x0; reset asserted in WAIT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is visible combinationally on rd_data.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CNT_W = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [IDX_W-1:0] rd_idx_reg;
  logic [IDX_W-1:0] wr_idx_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // Indices wrap explicitly so non-power-of-two depths work.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_reg[rd_idx_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_idx_reg <= '0;
      wr_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_idx_reg <= next_idx(wr_idx_reg);
      if (do_rd) rd_idx_reg <= next_idx(rd_idx_reg);
      if (do_wr && !do_rd)
        count_reg <= count_reg + 1'b1;
      else if (do_rd && !do_wr)
        count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush && !reset)
      mem_reg[wr_idx_reg] <= wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and
// buffers {pc,instr} pairs for decode, with absolute/relative redirect and flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                PC_STEP    = 4,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic               redirect_rel,
  input  logic [ADDR_W-1:0]  redirect_base,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  input  logic               id_ready
);

  localparam int                CNT_W     = fifo_ptr_w(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);

  fetch_state_e              state_reg;
  logic [ADDR_W-1:0]         fetch_pc_reg;
  logic [ADDR_W-1:0]         req_pc_reg;
  logic [ADDR_W-1:0]         new_pc;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic                      fifo_wr;
  logic                      fifo_rd;
  logic                      issue;
  logic [ADDR_W+INSTR_W-1:0] fifo_rd_data;

  assign new_pc = redirect_rel ? redirect_base + redirect_target : redirect_target;

  // With nothing outstanding in REQ, a free FIFO slot is what reserves room for the reply.
  assign imem_req  = !reset && (state_reg == REQ) && (fifo_count < DEPTH_CNT);
  assign imem_addr = fetch_pc_reg;
  assign issue     = imem_req && imem_gnt;

  assign id_valid = !reset && !fifo_empty;
  assign fifo_rd  = id_valid && id_ready && !redirect_valid;
  assign fifo_wr  = (state_reg == WAIT) && imem_rvalid && !redirect_valid;
  assign {id_pc, id_instr} = fifo_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= REQ;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
    end else begin
      if (issue) begin
        req_pc_reg   <= fetch_pc_reg;
        fetch_pc_reg <= fetch_pc_reg + STEP;
      end
      if (redirect_valid)
        fetch_pc_reg <= new_pc;
      case (state_reg)
        REQ:  if (issue) state_reg <= redirect_valid ? DROP : WAIT;
        WAIT: begin
          if (imem_rvalid)
            state_reg <= REQ;
          else if (redirect_valid)
            state_reg <= DROP;
        end
        // A reply arriving alongside a further redirect still retires the stale request.
        DROP: if (imem_rvalid) state_reg <= REQ;
        default: state_reg <= REQ;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .wr_en   (fifo_wr),
    .wr_data ({req_pc_reg, imem_rdata}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int          AW     = 32;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 2;
  localparam int          STEP   = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect_valid, redirect_rel, imem_req, imem_gnt, imem_rvalid;
  logic        id_valid, id_ready;
  logic [31:0] redirect_base, redirect_target, imem_addr, imem_rdata, id_pc, id_instr;

  fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RST_PC), .PC_STEP(STEP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_rel(redirect_rel),
    .redirect_base(redirect_base), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic rel; logic [31:0] base; logic [31:0] tgt; logic [31:0] exp_pc; } redir_vec_t;

  int tests = 0;
  int fails = 0;

  // Model: instructions the ID stage is owed, in order, and the next program-order PC.
  ent_t        exp_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] gnt_addr[$];
  logic [31:0] exp_pc;
  bit          mem_busy, mem_stale;
  int          mem_cnt;
  logic [31:0] mem_addr, pend_pc;

  bit          drv_reset, drv_gnt, drv_ready, drv_redir, drv_rel, rand_mode;
  logic [31:0] drv_base, drv_tgt;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, sample and update the model at posedge+4.
  task automatic cycle();
    logic        rv;
    logic [31:0] npc;
    logic [7:0]  off;
    reset = drv_reset;
    if (rand_mode) begin
      imem_gnt        = ($urandom_range(0, 3) != 0);
      id_ready        = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_rel    = 1'($urandom_range(0, 1));
      redirect_base   = $urandom & 32'hFFFF_FFFC;
      off             = 8'($urandom);
      redirect_target = redirect_rel ? {{22{off[7]}}, off, 2'b00} : ($urandom & 32'hFFFF_FFFC);
    end else begin
      imem_gnt        = drv_gnt;
      id_ready        = drv_ready;
      redirect_valid  = drv_redir;
      redirect_rel    = drv_rel;
      redirect_base   = drv_base;
      redirect_target = drv_tgt;
    end
    rv = 1'b0;
    if (mem_busy && !drv_reset) begin
      mem_cnt--;
      if (mem_cnt == 0) rv = 1'b1;
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(mem_addr) : $urandom;
    #3;
    if (drv_reset) begin
      chk("reset_req", 32'(imem_req), 0);
      chk("reset_id_valid", 32'(id_valid), 0);
      exp_q.delete();
      exp_pc    = RST_PC;
      mem_busy  = 0;
      mem_stale = 0;
    end else begin
      chk("req", 32'(imem_req), 32'(!mem_busy && exp_q.size() < DEPTH));
      chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
      if (id_valid && id_ready && !redirect_valid && exp_q.size() != 0) begin
        chk("id_pc", id_pc, exp_q[0].pc);
        chk("id_instr", id_instr, exp_q[0].instr);
        got_pc.push_back(id_pc);
        void'(exp_q.pop_front());
      end
      if (rv) begin
        mem_busy = 0;
        if (!mem_stale && !redirect_valid)
          exp_q.push_back(ent_t'({pend_pc, mem_word(pend_pc)}));
      end
      if (imem_req && imem_gnt) begin
        chk("grant_addr", imem_addr, exp_pc);
        gnt_addr.push_back(imem_addr);
        mem_busy  = 1;
        mem_cnt   = $urandom_range(lat_min, lat_max);
        mem_addr  = imem_addr;
        mem_stale = 0;
        pend_pc   = exp_pc;
        exp_pc    = exp_pc + STEP;
      end
      if (redirect_valid) begin
        exp_q.delete();
        if (mem_busy) mem_stale = 1;
        npc    = redirect_rel ? redirect_base + redirect_target : redirect_target;
        exp_pc = npc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_cycle(input logic rel, input logic [31:0] base, input logic [31:0] tgt);
    drv_redir = 1; drv_rel = rel; drv_base = base; drv_tgt = tgt;
    cycle();
    drv_redir = 0;
  endtask

  task automatic do_reset();
    drv_reset = 1;
    cycle();
    cycle();
    drv_reset = 0;
    got_pc.delete();
    gnt_addr.delete();
  endtask

  task automatic run_until_got(input int n, input int budget, input string name);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      cycle();
      k++;
    end
    tests++;
    if (got_pc.size() < n) begin
      fails++;
      $display("FAIL %s: timeout, got %0d of %0d instrs", name, got_pc.size(), n);
    end
  endtask

  task automatic chk_got(input string name, input int i, input logic [31:0] exp);
    if (got_pc.size() > i) chk(name, got_pc[i], exp);
  endtask

  redir_vec_t vecs[6];

  initial begin
    reset = 1; redirect_valid = 0; redirect_rel = 0; redirect_base = 0; redirect_target = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; id_ready = 0;
    drv_reset = 1; drv_gnt = 0; drv_ready = 0; drv_redir = 0; drv_rel = 0; rand_mode = 0;
    drv_base = 0; drv_tgt = 0; exp_pc = RST_PC; mem_busy = 0; mem_stale = 0; mem_cnt = 0;
    mem_addr = 0; pend_pc = 0;

    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'hFFFF_FFF0, 32'h0000_0010};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0004};
    vecs[3] = '{1'b0, 32'h1234_0000, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
    vecs[4] = '{1'b1, 32'h0000_1000, 32'h0000_0040, 32'h0000_1040};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC};

    @(posedge clk);
    #1;

    // Sequential stream with single-cycle memory.
    do_reset();
    chk("reset_addr", imem_addr, RST_PC);
    drv_gnt = 1; drv_ready = 1; lat_min = 1; lat_max = 1;
    cycle();
    cycle();
    chk("latency_early", 32'(got_pc.size()), 0);
    cycle();
    chk("latency", 32'(got_pc.size()), 1);
    run_until_got(5, 40, "seq");
    for (int i = 0; i < 5; i++) chk_got("seq_pc", i, 32'(4 * i));
    $display("[TB] sequential stream: %0d instrs", got_pc.size());

    // Back-pressure: FIFO fills to DEPTH, outputs held, fetch resumes at PC 8.
    do_reset();
    drv_gnt = 1; drv_ready = 0;
    repeat (8) cycle();
    chk("hold_pc", id_pc, 32'h0);
    chk("hold_instr", id_instr, mem_word(32'h0));
    chk("hold_req", 32'(imem_req), 0);
    repeat (3) cycle();
    chk("hold_pc2", id_pc, 32'h0);
    gnt_addr.delete();
    drv_ready = 1;
    run_until_got(3, 40, "resume");
    chk_got("resume_pc0", 0, 32'h0);
    chk_got("resume_pc1", 1, 32'h4);
    chk_got("resume_pc2", 2, 32'h8);
    if (gnt_addr.size() > 0) chk("resume_gnt", gnt_addr[0], 32'h8);
    $display("[TB] back-pressure: resumed with %0d grants", gnt_addr.size());

    // Absolute redirect while waiting on memory.
    do_reset();
    drv_ready = 1; lat_min = 4; lat_max = 4; drv_gnt = 1;
    cycle();
    drv_gnt = 0;
    cycle();
    redirect_cycle(1'b0, 32'h0, 32'h100);
    chk("wait_redir_req", 32'(imem_req), 0);
    drv_gnt = 1;
    run_until_got(2, 40, "wait_redir");
    chk_got("wait_redir_pc0", 0, 32'h100);
    chk_got("wait_redir_pc1", 1, 32'h104);
    $display("[TB] redirect in WAIT: first pc %h", got_pc.size() > 0 ? got_pc[0] : 32'h0);

    // Relative redirect with the FIFO full.
    do_reset();
    lat_min = 1; lat_max = 1; drv_gnt = 1; drv_ready = 0;
    repeat (6) cycle();
    redirect_cycle(1'b1, 32'h20, 32'hFFFF_FFF0);
    chk("flush_valid", 32'(id_valid), 0);
    chk("flush_req", 32'(imem_req), 1);
    chk("flush_addr", imem_addr, 32'h10);
    drv_ready = 1;
    run_until_got(1, 30, "flush");
    chk_got("flush_pc", 0, 32'h10);
    $display("[TB] relative redirect with full FIFO");

    // Redirect coincident with grant.
    do_reset();
    drv_gnt = 0; drv_ready = 1; lat_min = 2; lat_max = 2;
    cycle();
    drv_gnt = 1;
    redirect_cycle(1'b0, 32'h0, 32'h200);
    drv_gnt = 0;
    chk("gnt_redir_req", 32'(imem_req), 0);
    drv_gnt = 1;
    run_until_got(1, 30, "gnt_redir");
    chk_got("gnt_redir_pc", 0, 32'h200);
    $display("[TB] redirect with grant");

    // Redirect coincident with rvalid.
    do_reset();
    lat_min = 3; lat_max = 3; drv_gnt = 1;
    cycle();
    drv_gnt = 0;
    cycle();
    cycle();
    redirect_cycle(1'b0, 32'h0, 32'h300);
    chk("rv_redir_req", 32'(imem_req), 1);
    chk("rv_redir_addr", imem_addr, 32'h300);
    drv_gnt = 1;
    run_until_got(1, 30, "rv_redir");
    chk_got("rv_redir_pc", 0, 32'h300);
    $display("[TB] redirect with rvalid");

    // Table of redirect targets, including address wrap.
    lat_min = 1; lat_max = 2;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      drv_ready = 1; drv_gnt = 0;
      cycle();
      redirect_cycle(vecs[v].rel, vecs[v].base, vecs[v].tgt);
      chk("vec_addr", imem_addr, vecs[v].exp_pc);
      drv_gnt = 1;
      run_until_got(2, 40, "vec");
      chk_got("vec_pc0", 0, vecs[v].exp_pc);
      chk_got("vec_pc1", 1, vecs[v].exp_pc + 32'd4);
      $display("[TB] vec %0d rel=%0d base=%h tgt=%h -> %h", v, vecs[v].rel, vecs[v].base,
               vecs[v].tgt, vecs[v].exp_pc);
    end

    // Reset while a request is outstanding.
    do_reset();
    lat_min = 5; lat_max = 5; drv_gnt = 1; drv_ready = 1;
    cycle();
    drv_gnt = 0;
    cycle();
    cycle();
    do_reset();
    drv_gnt = 1; lat_min = 1; lat_max = 1;
    run_until_got(2, 30, "reset_wait");
    chk_got("reset_wait_pc0", 0, 32'h0);
    chk_got("reset_wait_pc1", 1, 32'h4);
    $display("[TB] reset in WAIT");

    // Random gnt stalls, latency 1..5, redirects and back-pressure.
    do_reset();
    lat_min = 1; lat_max = 5; rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      cycle();
    end
    rand_mode = 0;
    tests++;
    if (got_pc.size() < 50) begin
      fails++;
      $display("FAIL random_progress: got %0d instrs, required at least 50", got_pc.size());
    end
    $display("[TB] random phase: %0d instrs delivered after last reset", got_pc.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
